rf_writeback_ctrl: RTL and testbench

//  Writer side of the int/FP register-file write port (WBctl/rd/isfloat_rd/val3).

---
 rtl/rf_writeback_ctrl.sv | 151 +++++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// rf_writeback_ctrl
//   Drives the single register-file write port (WBctl/rd/isfloat_rd/val3) from
//   two sources:
//     - the in-order pipeline WB stage (priority, cannot be back-pressured);
//     - a long-latency unit (mul/div/fdiv), queued in a DEPTH-entry FIFO.
//   Also exports per-register pending masks for the queued results and a
//   one-cycle stall request that lets a starved FIFO head through.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   pipe_wb_valid/rd/isfloat/data  pipeline WB result (no handshake)
//   lu_valid/lu_ready            long-latency handshake, transfer on both high
//   lu_rd/lu_isfloat/lu_data     long-latency result fields
//   WBctl/rd/isfloat_rd/val3     register-file write port (combinational)
//   stall_o                      pipeline must hold its WB result this cycle
//   pend_int/pend_fp             destinations of queued results (x0 never set)
// -----------------------------------------------------------------------------
module rf_writeback_ctrl #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_rd,
  input  logic        pipe_isfloat,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic        lu_isfloat,
  input  logic [31:0] lu_data,
  output logic        WBctl,
  output logic [4:0]  rd,
  output logic        isfloat_rd,
  output logic [31:0] val3,
  output logic        stall_o,
  output logic [31:0] pend_int,
  output logic [31:0] pend_fp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  // FIFO payload storage; validity is derived from the pointers and count.
  logic [4:0]  mem_rd   [DEPTH];
  logic        mem_fp   [DEPTH];
  logic [31:0] mem_data [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic non_empty, full, push, head_grant;
  logic [DEPTH-1:0] entry_valid;

  assign non_empty = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  // Gating with rst keeps every output quiet for as long as reset is held.
  assign lu_ready  = ~full & ~rst;
  assign push      = lu_valid & lu_ready;
  assign stall_o   = ~rst & non_empty & (starve_q == SW'(STARVE_MAX));
  // The head goes out when forced by a stall or when the pipeline is silent.
  assign head_grant = ~rst & non_empty & (stall_o | ~pipe_wb_valid);

  // An entry is live if its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PW-1:0] offset;
    assign offset          = PW'(gi) - rd_ptr_q;
    assign entry_valid[gi] = (CW'(offset) < count_q);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (head_grant) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(head_grant);
    if (!non_empty || head_grant) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Payload needs no reset: nothing reads an entry that the count says is dead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr_q]   <= lu_rd;
      mem_fp[wr_ptr_q]   <= lu_isfloat;
      mem_data[wr_ptr_q] <= lu_data;
    end
  end

  // Write-port mux.
  always_comb begin
    WBctl      = 1'b0;
    rd         = '0;
    isfloat_rd = 1'b0;
    val3       = '0;
    if (head_grant) begin
      // An integer x0 head is still popped, just never written.
      WBctl      = mem_fp[rd_ptr_q] | (mem_rd[rd_ptr_q] != 5'd0);
      rd         = mem_rd[rd_ptr_q];
      isfloat_rd = mem_fp[rd_ptr_q];
      val3       = mem_data[rd_ptr_q];
    end else if (!rst && pipe_wb_valid) begin
      WBctl      = 1'b1;
      rd         = pipe_rd;
      isfloat_rd = pipe_isfloat;
      val3       = pipe_data;
    end
  end

  // Pending masks over live entries.
  always_comb begin
    pend_int = '0;
    pend_fp  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        if (mem_fp[i]) pend_fp[mem_rd[i]]  = 1'b1;
        else           pend_int[mem_rd[i]] = 1'b1;
      end
    end
    pend_int[0] = 1'b0;
    if (rst) begin
      pend_int = '0;
      pend_fp  = '0;
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
module tb_rf_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_rd;
  logic        pipe_isfloat;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic        lu_isfloat;
  logic [31:0] lu_data;
  logic        WBctl;
  logic [4:0]  rd;
  logic        isfloat_rd;
  logic [31:0] val3;
  logic        stall_o;
  logic [31:0] pend_int;
  logic [31:0] pend_fp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_writeback_ctrl #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_valid(pipe_wb_valid), .pipe_rd(pipe_rd),
    .pipe_isfloat(pipe_isfloat), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd),
    .lu_isfloat(lu_isfloat), .lu_data(lu_data),
    .WBctl(WBctl), .rd(rd), .isfloat_rd(isfloat_rd), .val3(val3),
    .stall_o(stall_o), .pend_int(pend_int), .pend_fp(pend_fp)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    pipe_wb_valid = 1'b0; pipe_rd = '0; pipe_isfloat = 1'b0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_isfloat = 1'b0; lu_data = '0;
  endtask

  task automatic test_reset;
    next_cycle;
    rst = 1'b1;
    pipe_wb_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd2; lu_data = 32'h2;
    #3;
    checks++; if (WBctl !== 1'b0) begin errors++; $display("FAIL reset_wbctl got %b want 0", WBctl); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got %b want 0", lu_ready); end
    checks++; if (stall_o !== 1'b0 || rd !== 5'd0 || val3 !== 32'h0) begin errors++;
      $display("FAIL reset_outs got stall=%b rd=%0d val3=%h want 0/0/0", stall_o, rd, val3); end
    $display("reset held: WBctl=%b lu_ready=%b", WBctl, lu_ready);
    next_cycle;
    rst = 1'b0;
    drive_idle;
    #3;
    checks++; if (WBctl !== 1'b0) begin errors++; $display("FAIL post_reset_wbctl got %b want 0", WBctl); end
    checks++; if (pend_int !== 32'h0 || pend_fp !== 32'h0) begin errors++;
      $display("FAIL post_reset_pend got int=%h fp=%h want 0/0", pend_int, pend_fp); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_lu_ready got %b want 1", lu_ready); end
    $display("reset released: WBctl=%b pend_int=%h pend_fp=%h", WBctl, pend_int, pend_fp);
  endtask

  task automatic test_pipe_only;
    next_cycle;
    pipe_wb_valid = 1'b1; pipe_rd = 5'd5; pipe_isfloat = 1'b0; pipe_data = 32'h1234;
    #3;
    checks++; if (WBctl !== 1'b1 || rd !== 5'd5 || isfloat_rd !== 1'b0 || val3 !== 32'h1234) begin errors++;
      $display("FAIL pipe_only got we=%b rd=%0d fp=%b val3=%h want 1/5/0/1234", WBctl, rd, isfloat_rd, val3); end
    $display("pipe write: rd=%0d val3=%h", rd, val3);
    next_cycle;
    pipe_rd = 5'd0; pipe_isfloat = 1'b0; pipe_data = 32'h55;
    #3;
    checks++; if (WBctl !== 1'b1 || rd !== 5'd0 || val3 !== 32'h55) begin errors++;
      $display("FAIL pipe_x0 got we=%b rd=%0d val3=%h want 1/0/55", WBctl, rd, val3); end
    $display("pipe x0 write: WBctl=%b", WBctl);
    next_cycle;
    drive_idle;
    #3;
  endtask

  task automatic test_drain_idle;
    next_cycle;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_isfloat = 1'b1; lu_data = 32'hCAFE;
    #3;
    checks++; if (WBctl !== 1'b0 || pend_fp !== 32'h0) begin errors++;
      $display("FAIL drain_no_bypass got we=%b pend_fp=%h want 0/0", WBctl, pend_fp); end
    next_cycle;
    lu_valid = 1'b0;
    #3;
    checks++; if (WBctl !== 1'b1 || rd !== 5'd3 || isfloat_rd !== 1'b1 || val3 !== 32'hCAFE) begin errors++;
      $display("FAIL drain_write got we=%b rd=%0d fp=%b val3=%h want 1/3/1/cafe", WBctl, rd, isfloat_rd, val3); end
    checks++; if (pend_fp !== 32'h8) begin errors++; $display("FAIL drain_pend got %h want 8", pend_fp); end
    $display("drain write: rd=%0d fp=%b val3=%h", rd, isfloat_rd, val3);
    next_cycle;
    #3;
    checks++; if (pend_fp !== 32'h0 || WBctl !== 1'b0) begin errors++;
      $display("FAIL drain_after got pend_fp=%h we=%b want 0/0", pend_fp, WBctl); end
  endtask

  task automatic test_full;
    logic [31:0] exp_pend [7];
    exp_pend[0] = 32'h1E; exp_pend[1] = 32'h1E; exp_pend[2] = 32'h1E;
    exp_pend[3] = 32'h1C; exp_pend[4] = 32'h38; exp_pend[5] = 32'h30; exp_pend[6] = 32'h20;
    for (int k = 0; k < 4; k++) begin
      next_cycle;
      pipe_wb_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h7777;
      lu_valid = 1'b1; lu_rd = 5'(k + 1); lu_isfloat = 1'b0; lu_data = 32'h101 + 32'(k);
      #3;
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %b want 1", k, lu_ready); end
      checks++; if (WBctl !== 1'b1 || rd !== 5'd7) begin errors++;
        $display("FAIL full_pipe_%0d got we=%b rd=%0d want 1/7", k, WBctl, rd); end
      $display("push %0d: rd=%0d lu_ready=%b", k, lu_rd, lu_ready);
    end
    // cycles c4..c10 relative to first push
    for (int c = 4; c <= 10; c++) begin
      next_cycle;
      if (c == 4) begin lu_rd = 5'd5; lu_data = 32'h105; end
      if (c == 6) pipe_wb_valid = 1'b0;
      if (c == 8) lu_valid = 1'b0;
      #3;
      if (c <= 6) begin
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_c%0d got %b want 0", c, lu_ready); end
      end
      if (c == 7) begin
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_c7 got %b want 1", lu_ready); end
      end
      if (c <= 5) begin
        checks++; if (rd !== 5'd7 || stall_o !== 1'b0) begin errors++;
          $display("FAIL full_hold_c%0d got rd=%0d stall=%b want 7/0", c, rd, stall_o); end
      end else begin
        checks++; if (WBctl !== 1'b1 || rd !== 5'(c - 5) || val3 !== 32'h100 + 32'(c - 5)) begin errors++;
          $display("FAIL full_pop_c%0d got we=%b rd=%0d val3=%h want 1/%0d/%h", c, WBctl, rd, val3, c - 5, 32'h100 + 32'(c - 5)); end
      end
      checks++; if (pend_int !== exp_pend[c - 4]) begin errors++;
        $display("FAIL full_pend_c%0d got %h want %h", c, pend_int, exp_pend[c - 4]); end
      $display("cycle c%0d: WBctl=%b rd=%0d val3=%h lu_ready=%b", c, WBctl, rd, val3, lu_ready);
    end
    next_cycle;
    drive_idle;
    #3;
    checks++; if (WBctl !== 1'b0 || pend_int !== 32'h0) begin errors++;
      $display("FAIL full_empty got we=%b pend_int=%h want 0/0", WBctl, pend_int); end
  endtask

  task automatic test_starvation;
    logic        exp_stall;
    logic [31:0] exp_pend;
    next_cycle;
    pipe_wb_valid = 1'b1; pipe_rd = 5'd10; pipe_isfloat = 1'b0; pipe_data = 32'h5555;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_isfloat = 1'b0; lu_data = 32'hBEEF;
    #3;
    checks++; if (stall_o !== 1'b0 || rd !== 5'd10) begin errors++;
      $display("FAIL starve_push got stall=%b rd=%0d want 0/10", stall_o, rd); end
    for (int k = 1; k <= 20; k++) begin
      next_cycle;
      lu_valid = 1'b0;
      #3;
      exp_stall = (k == 9);
      exp_pend  = (k <= 9) ? 32'h200 : 32'h0;
      checks++; if (stall_o !== exp_stall) begin errors++;
        $display("FAIL starve_stall_k%0d got %b want %b", k, stall_o, exp_stall); end
      checks++; if (WBctl !== 1'b1 || rd !== (exp_stall ? 5'd9 : 5'd10) || val3 !== (exp_stall ? 32'hBEEF : 32'h5555)) begin errors++;
        $display("FAIL starve_port_k%0d got we=%b rd=%0d val3=%h", k, WBctl, rd, val3); end
      checks++; if (pend_int !== exp_pend) begin errors++;
        $display("FAIL starve_pend_k%0d got %h want %h", k, pend_int, exp_pend); end
      $display("starve cycle %0d: stall_o=%b rd=%0d val3=%h", k, stall_o, rd, val3);
    end
    next_cycle;
    drive_idle;
    #3;
  endtask

  task automatic test_x0_drop;
    next_cycle;
    lu_valid = 1'b1; lu_rd = 5'd0; lu_isfloat = 1'b0; lu_data = 32'hDEAD;
    #3;
    checks++; if (WBctl !== 1'b0 || pend_int !== 32'h0) begin errors++;
      $display("FAIL x0_push got we=%b pend_int=%h want 0/0", WBctl, pend_int); end
    next_cycle;
    lu_rd = 5'd6; lu_isfloat = 1'b1; lu_data = 32'h66;
    #3;
    checks++; if (WBctl !== 1'b0 || pend_int !== 32'h0 || pend_fp !== 32'h0) begin errors++;
      $display("FAIL x0_pop got we=%b pend_int=%h pend_fp=%h want 0/0/0", WBctl, pend_int, pend_fp); end
    $display("x0 pop: WBctl=%b", WBctl);
    next_cycle;
    lu_valid = 1'b0;
    #3;
    checks++; if (WBctl !== 1'b1 || rd !== 5'd6 || isfloat_rd !== 1'b1 || val3 !== 32'h66 || pend_fp !== 32'h40) begin errors++;
      $display("FAIL x0_next got we=%b rd=%0d fp=%b val3=%h pend_fp=%h want 1/6/1/66/40", WBctl, rd, isfloat_rd, val3, pend_fp); end
    next_cycle;
    #3;
    checks++; if (WBctl !== 1'b0 || pend_fp !== 32'h0) begin errors++;
      $display("FAIL x0_empty got we=%b pend_fp=%h want 0/0", WBctl, pend_fp); end
  endtask

  task automatic test_mid_reset;
    next_cycle;
    pipe_wb_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h77;
    lu_valid = 1'b1; lu_rd = 5'd11; lu_isfloat = 1'b0; lu_data = 32'hB;
    next_cycle;
    lu_rd = 5'd12; lu_isfloat = 1'b1; lu_data = 32'hC;
    next_cycle;
    lu_valid = 1'b0;
    #3;
    checks++; if (pend_int !== 32'h800 || pend_fp !== 32'h1000) begin errors++;
      $display("FAIL midrst_pend got int=%h fp=%h want 800/1000", pend_int, pend_fp); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (WBctl !== 1'b0 || lu_ready !== 1'b0 || pend_int !== 32'h0 || pend_fp !== 32'h0) begin errors++;
      $display("FAIL midrst_async got we=%b ready=%b int=%h fp=%h want 0/0/0/0", WBctl, lu_ready, pend_int, pend_fp); end
    next_cycle;
    rst = 1'b0;
    drive_idle;
    #3;
    checks++; if (WBctl !== 1'b0 || pend_int !== 32'h0 || pend_fp !== 32'h0 || lu_ready !== 1'b1) begin errors++;
      $display("FAIL midrst_discard got we=%b int=%h fp=%h ready=%b want 0/0/0/1", WBctl, pend_int, pend_fp, lu_ready); end
    $display("mid-op reset: queue discarded, WBctl=%b", WBctl);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle;
    test_reset;
    test_pipe_only;
    test_drain_idle;
    test_full;
    test_starvation;
    test_x0_drop;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
